// File: rtl/piso_rr_scheduler.sv
// Round-robin scheduler feeding one parallel-in/serial-out shifter.
// Build with PISO_PARITY_EN defined to append an even-parity bit.
// Ports: clk, rst (sync, active-low), req[N_REQ], data[N_REQ*WIDTH],
//        ack[N_REQ], grant_id, so, so_valid, busy.
module piso_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*WIDTH-1:0]     data,
  output logic [N_REQ-1:0]           ack,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       so,
  output logic                       so_valid,
  output logic                       busy
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
  } state_t;
`endif

  state_t          state;
  state_t          nxt;
  logic [IW-1:0]   ptr;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]   cnt;
  logic [IW-1:0]   g;
  logic            grant;
  logic [WIDTH-1:0] word;
`ifdef PISO_PARITY_EN
  logic            par;
`endif

  // first set request at or after ptr, wrapping
  always_comb begin
    g = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[ptr + IW'(k)]) g = ptr + IW'(k);
    end
  end

  assign grant = (state == IDLE) && (|req);
  assign word  = data[int'(g)*WIDTH +: WIDTH];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (1'b1)
      (state == IDLE): begin
        if (|req) nxt = SHIFT;
      end
      (state == SHIFT): begin
`ifdef PISO_PARITY_EN
        if (cnt == LAST) nxt = PARITY;
`else
        if (cnt == LAST) nxt = IDLE;
`endif
      end
`ifdef PISO_PARITY_EN
      (state == PARITY): nxt = IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr      <= '0;
      sreg     <= '0;
      cnt      <= '0;
      ack      <= '0;
      grant_id <= '0;
`ifdef PISO_PARITY_EN
      par      <= 1'b0;
`endif
    end else begin
      ack <= '0;
      if (grant) begin
        sreg     <= word;
        cnt      <= '0;
        grant_id <= g;
        ack      <= N_REQ'(1) << g;
        ptr      <= g + IW'(1);
`ifdef PISO_PARITY_EN
        par      <= ^word;
`endif
      end else if (state == SHIFT) begin
        sreg <= {sreg[WIDTH-2:0], 1'b0};
        cnt  <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    so       = 1'b0;
    so_valid = 1'b0;
    busy     = 1'b0;
    unique case (1'b1)
      (state == SHIFT): begin
        so       = sreg[WIDTH-1];
        so_valid = 1'b1;
        busy     = 1'b1;
      end
`ifdef PISO_PARITY_EN
      (state == PARITY): begin
        so       = par;
        so_valid = 1'b1;
        busy     = 1'b1;
      end
`endif
      default: begin
        so       = 1'b0;
        so_valid = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

endmodule
